// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-split helpers for the
// direct-mapped instruction cache.
package icache_pkg;

    localparam int DEF_LINES          = 16;
    localparam int DEF_WORDS_PER_LINE = 4;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    // Byte-offset bits covering one line (word select plus the 2 byte bits).
    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words_per_line);
        return 32 - off_w(words_per_line) - idx_w(lines);
    endfunction

    localparam int OFF_W = off_w(DEF_WORDS_PER_LINE);
    localparam int IDX_W = idx_w(DEF_LINES);
    localparam int TAG_W = tag_w(DEF_LINES, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/icache_mem_if.sv
// Refill bus between the cache (master) and backing memory (slave):
// a held request with a line address, answered by single-cycle data beats.
interface icache_mem_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_data,
        output mem_valid
    );

endinterface

// File: rtl/icache_refill_fsm.sv
// Line-refill sequencer: latches the missing line address, holds the memory
// request and counts beats until the whole line has been accepted.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int LINE_W         = 32 - off_w(DEF_WORDS_PER_LINE)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              start_i,
    input  logic [LINE_W-1:0]                 line_i,
    input  logic                              mem_valid_i,
    input  logic                              invalidate_i,
    output state_t                            state_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] beat_o,
    output logic                              beat_we_o,
    output logic                              done_o,
    output logic                              abort_o,
    output logic                              mem_req_o,
    output logic [31:0]                       mem_addr_o,
    output logic [LINE_W-1:0]                 line_o
);

    localparam int                BEAT_W    = $clog2(WORDS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                abort_q, abort_d;
    logic                req_q, req_d;
    logic [LINE_W-1:0]   line_q, line_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            abort_q <= abort_d;
            req_q   <= req_d;
            line_q  <= line_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        abort_d   = abort_q;
        req_d     = req_q;
        line_d    = line_q;
        beat_we_o = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    line_d  = line_i;
                    req_d   = 1'b1;
                    beat_d  = '0;
                    abort_d = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                // An invalidate only marks the line; the burst is still drained.
                if (invalidate_i) begin
                    abort_d = 1'b1;
                end
                if (mem_valid_i) begin
                    beat_we_o = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        done_o  = 1'b1;
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o    = state_q;
    assign beat_o     = beat_q;
    assign abort_o    = abort_q;
    assign mem_req_o  = req_q;
    assign line_o     = line_q;
    assign mem_addr_o = {line_q, {(32 - LINE_W){1'b0}}};

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hit path over
// flop arrays, with misses filled line-at-a-time by icache_refill_fsm.
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         rd_en_i,
    input  logic [31:0]  addr_i,
    input  logic         invalidate_i,
    output logic [31:0]  data_o,
    output logic         valid_o,
    icache_mem_if.master mem
);

    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE);
    localparam int LINE_W = 32 - OFF_W;
    localparam int BEAT_W = $clog2(WORDS_PER_LINE);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [BEAT_W-1:0] req_word;
    logic              unused_addr_bits;

    assign req_tag          = addr_i[31 -: TAG_W];
    assign req_idx          = addr_i[OFF_W +: IDX_W];
    assign req_word         = addr_i[2 +: BEAT_W];
    assign unused_addr_bits = ^addr_i[1:0];

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic              beat_we, done, abort, start, hit, mem_req;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] line;
    logic [IDX_W-1:0]  refill_idx;
    logic [TAG_W-1:0]  refill_tag;

    assign refill_idx = line[IDX_W-1:0];
    assign refill_tag = line[LINE_W-1:IDX_W];

    // Hits are only served from IDLE: no hit-under-miss.
    assign hit     = rd_en_i && (state == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign valid_o = hit;
    assign data_o  = hit ? data_q[req_idx][req_word] : '0;
    assign start   = rd_en_i && (state == IDLE) && !hit && !invalidate_i;

    icache_refill_fsm #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINE_W         (LINE_W)
    ) u_refill_fsm (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start),
        .line_i       (addr_i[31:OFF_W]),
        .mem_valid_i  (mem.mem_valid),
        .invalidate_i (invalidate_i),
        .state_o      (state),
        .beat_o       (beat),
        .beat_we_o    (beat_we),
        .done_o       (done),
        .abort_o      (abort),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .line_o       (line)
    );

    assign mem.mem_req  = mem_req;
    assign mem.mem_addr = mem_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (invalidate_i) begin
            valid_q <= '0;
        end else if (done && !abort) begin
            valid_q[refill_idx] <= 1'b1;
        end else if (start) begin
            valid_q[req_idx] <= 1'b0;
        end
    end

    // NOTE: tag/data arrays have no reset; valid_q alone decides whether their contents are used.
    always_ff @(posedge clk_i) begin
        if (beat_we) begin
            data_q[refill_idx][beat] <= mem.mem_data;
            if (beat == '0) begin
                tag_q[refill_idx] <= refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus random fetch
// traffic, all compared each cycle against a line-level cache model.
module tb_instr_cache;
    import icache_pkg::*;

    localparam int LINES      = 16;
    localparam int WPL        = 4;
    localparam int LINE_BYTES = 4 * WPL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        invalidate = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_o;
    logic        valid_o;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_rate = 100;
    int mem_beat = 0;

    icache_mem_if mem_bus ();

    instr_cache #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rd_en_i      (rd_en),
        .addr_i       (addr),
        .invalidate_i (invalidate),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory image: fixed words for the directed lines, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'h10) return 32'h11 * (w / 4 + 1);
        if (w >= 32'h100 && w < 32'h110) return 32'hA0 + (w - 32'h100) / 4;
        return {w[15:0], ~w[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / LINE_BYTES) % LINES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (LINE_BYTES * LINES);
    endfunction

    // Line-level model: which lines hold which tags, and the refill in flight.
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    bit          m_busy, m_abort, m_addr_fresh;
    logic [31:0] m_line;
    int          m_beats;

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy       = 1'b0;
            m_abort      = 1'b0;
            m_line       = '0;
            m_beats      = 0;
            m_addr_fresh = 1'b1;
        end else if (!m_busy) begin
            if (invalidate) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (rd_en && !model_hit(addr)) begin
                m_busy       = 1'b1;
                m_abort      = 1'b0;
                m_beats      = 0;
                m_line       = addr & ~32'(LINE_BYTES - 1);
                m_addr_fresh = 1'b0;
                m_valid[idx_of(addr)] = 1'b0;
            end
        end else begin
            if (invalidate) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_abort = 1'b1;
            end
            if (mem_bus.mem_valid) begin
                m_beats++;
                if (m_beats == WPL) begin
                    m_busy = 1'b0;
                    if (!m_abort) begin
                        m_valid[idx_of(m_line)] = 1'b1;
                        m_tag[idx_of(m_line)]   = tag_of(m_line);
                    end
                end
            end
        end
    end

    // Compare process: outputs checked every cycle against the model.
    always @(negedge clk) begin
        bit exp_valid;
        #2;
        exp_valid = rst_n && rd_en && !m_busy && model_hit(addr);
        check("cmp valid_o", 32'(valid_o), 32'(exp_valid));
        check("cmp data_o", data_o, exp_valid ? mem_word(addr) : 32'h0);
        check("cmp mem_req_o", 32'(mem_bus.mem_req), 32'(m_busy));
        if (m_busy || m_addr_fresh) begin
            check("cmp mem_addr_o", mem_bus.mem_addr, m_line);
        end
    end

    // Memory responder: beats at mem_rate percent while requested, stray beats otherwise.
    always @(negedge clk) begin
        if (rst_n && mem_bus.mem_req && ($urandom_range(99) < 32'(mem_rate))) begin
            mem_bus.mem_valid = 1'b1;
            mem_bus.mem_data  = mem_word(mem_bus.mem_addr + 32'(4 * mem_beat));
        end else if (!mem_bus.mem_req && ($urandom_range(9) == 0)) begin
            mem_bus.mem_valid = 1'b1;
            mem_bus.mem_data  = $urandom;
        end else begin
            mem_bus.mem_valid = 1'b0;
            mem_bus.mem_data  = $urandom;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !mem_bus.mem_req) mem_beat = 0;
        else if (mem_bus.mem_valid) mem_beat++;
    end

    task automatic drive(input bit rd, input logic [31:0] a, input bit inv);
        @(negedge clk);
        rd_en      = rd;
        addr       = a;
        invalidate = inv;
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (mem_bus.mem_req && n < 40) begin
            drive(1'b0, 32'h0, 1'b0);
            n++;
        end
        check(name, 32'(mem_bus.mem_req), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_data  = '0;
        #1;
        check("reset valid_o", 32'(valid_o), 32'h0);
        check("reset data_o", data_o, 32'h0);
        check("reset mem_req_o", 32'(mem_bus.mem_req), 32'h0);
        check("reset mem_addr_o", mem_bus.mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold miss on line 0 and its four-beat refill.
        drive(1'b1, 32'h0, 1'b0);
        check("t1 miss valid_o", 32'(valid_o), 32'h0);
        check("t1 req not yet", 32'(mem_bus.mem_req), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        check("t1 mem_req_o", 32'(mem_bus.mem_req), 32'h1);
        check("t1 mem_addr_o", mem_bus.mem_addr, 32'h0);
        repeat (3) drive(1'b0, 32'h0, 1'b0);
        check("t2 req held to last beat", 32'(mem_bus.mem_req), 32'h1);
        drive(1'b1, 32'h0, 1'b0);
        check("t2 req dropped", 32'(mem_bus.mem_req), 32'h0);
        check("t2 hit 0x0 valid", 32'(valid_o), 32'h1);
        check("t2 hit 0x0 data", data_o, 32'h11);
        drive(1'b1, 32'hC, 1'b0);
        check("t2 hit 0xC data", data_o, 32'h44);
        drive(1'b1, 32'h6, 1'b0);
        check("t2 hit 0x6 data", data_o, 32'h22);

        // Conflict miss on index 0, tag 1.
        drive(1'b1, 32'h100, 1'b0);
        check("t3 conflict miss", 32'(valid_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        check("t3 mem_addr_o", mem_bus.mem_addr, 32'h100);
        repeat (3) drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h100, 1'b0);
        check("t3 hit 0x100 data", data_o, 32'hA0);
        drive(1'b1, 32'h0, 1'b0);
        check("t3 0x0 evicted", 32'(valid_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        check("t3 re-request 0x0", mem_bus.mem_addr, 32'h0);
        wait_idle("t3 refill completes");

        // Invalidate in IDLE.
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h4, 1'b0);
        check("t4 invalidated miss", 32'(valid_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        check("t4 req after invalidate", 32'(mem_bus.mem_req), 32'h1);
        wait_idle("t4 refill completes");

        // Invalidate on the second beat of a refill.
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        check("t5 beats still drained", 32'(mem_bus.mem_req), 32'h1);
        drive(1'b1, 32'h0, 1'b0);
        check("t5 req dropped", 32'(mem_bus.mem_req), 32'h0);
        check("t5 aborted line invalid", 32'(valid_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        check("t5 re-request", 32'(mem_bus.mem_req), 32'h1);
        check("t5 re-request addr", mem_bus.mem_addr, 32'h0);
        wait_idle("t5 refill completes");
        drive(1'b1, 32'h8, 1'b0);
        check("t5 hit 0x8 data", data_o, 32'h33);

        // Asynchronous reset between beats 2 and 3.
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6 async mem_req_o", 32'(mem_bus.mem_req), 32'h0);
        check("t6 async valid_o", 32'(valid_o), 32'h0);
        check("t6 async mem_addr_o", mem_bus.mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0, 1'b0);
        check("t6 line 0 invalid", 32'(valid_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0);
        check("t6 new request", 32'(mem_bus.mem_req), 32'h1);
        wait_idle("t6 refill completes");

        // Random traffic over 4 tags x 16 indices with throttled memory.
        mem_rate = 70;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(3) << 8) | ($urandom_range(15) << 4) | $urandom_range(15);
            drive($urandom_range(9) < 8, a, $urandom_range(49) == 0);
        end
        drive(1'b0, 32'h0, 1'b0);
        wait_idle("random drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
Direct-mapped, read-only instruction cache that answers the fetch stage's instruction requests. Hits return the instruction word and `valid` combinationally, in the same cycle as the address, so fetch can flop it into `instr_o`. On a miss, a refill FSM fetches the whole line from backing memory over a simple request/beat handshake, installs it, and then resumes serving hits. `invalidate_i` (fence.i / reset of code image) clears every line.

Parameters:
LINES, 16, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
rd_en_i  in  1  fetch requests instruction at addr_i this cycle
addr_i  in  32  byte address from fetch; bits [1:0] ignored
invalidate_i  in  1  single-cycle pulse: clear all valid bits
data_o  out  32  instruction word (0 when valid_o=0)
valid_o  out  1  hit: data_o holds the word at addr_i this cycle
mem_req_o  out  1  refill request, held high for the whole refill
mem_addr_o  out  32  line-aligned refill address, stable while mem_req_o=1
mem_data_i  in  32  refill beat data
mem_valid_i  in  1  one beat of mem_data_i valid this cycle

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE)+2 bits; IDX = log2(LINES) bits at addr[OFF+IDX-1:OFF]; TAG = addr[31:OFF+IDX]. Defaults: word sel addr[3:2], index addr[7:4], tag addr[31:8].
- Storage: valid[LINES], tag[LINES], data[LINES][WORDS_PER_LINE], all flops. Only valid bits are reset; tag/data arrays are not.
- Hit: valid_o = rd_en_i & state==IDLE & valid[idx] & tag[idx]==TAG. data_o = data[idx][word] on hit, else 0. Purely combinational, zero latency.
- Reset (async assert): valid[] = 0, state = IDLE, mem_req_o = 0, mem_addr_o = 0, beat counter = 0. valid_o and data_o = 0.
- FSM states:
  - IDLE: if rd_en_i and not a hit and not invalidate_i, latch line address {addr_i[31:OFF], OFF'b0} into mem_addr_o, set mem_req_o=1, clear beat counter, go to REFILL (registered, so mem_req_o rises the cycle after the miss).
  - REFILL: on each mem_valid_i, write mem_data_i to data[latched idx][beat] and increment beat. Write tag[idx] on the first beat and clear valid[idx] on refill entry. On the last beat (beat==WORDS_PER_LINE-1), set valid[idx]=1 (unless aborted), drop mem_req_o, and go to IDLE.
  - The hit can be seen no earlier than the cycle after the last beat. Refill-to-hit latency is therefore 1 + N beats + 1 cycles.
- valid_o is 0 throughout REFILL, including for addresses that would hit other lines. There is no hit-under-miss.
- addr_i changes or rd_en_i drops during REFILL: refill still completes for the latched line. The FSM then re-evaluates the new addr_i in IDLE.
- invalidate_i in IDLE: all valid bits clear next edge. A miss is not started in the same cycle.
- invalidate_i during REFILL: all valid bits clear and an abort flag is set. Remaining beats are still consumed, so memory is never left mid-burst. The line is written but left invalid. Return to IDLE, where the re-access misses.
- mem_valid_i outside REFILL is ignored.
- Reset mid-refill: mem_req_o drops immediately (async). Memory must tolerate an abandoned burst.

Decomposition:
- Package icache_pkg: state enum (IDLE, REFILL), and localparams for OFF/IDX/TAG widths derived from LINES and WORDS_PER_LINE.
- One natural sub-module, icache_refill_fsm: state, beat counter, abort flag, mem_req_o/mem_addr_o. The top level holds the arrays and the hit compare.

Test Plan:
1. Reset, then rd_en_i=1, addr_i=0x0000_0000 → valid_o=0; next cycle mem_req_o=1, mem_addr_o=0x0000_0000.
2. Continue 1: drive beats 0x11,0x22,0x33,0x44 on consecutive cycles → mem_req_o falls after the 4th beat. Next cycle addr 0x0 gives valid_o=1, data_o=0x11; addr 0xC gives data_o=0x44 in the same cycle; addr 0x6 gives 0x22.
3. Conflict: after 2, read 0x0000_0100 (index 0, tag 1) → miss, mem_addr_o=0x100. Refill 0xA0..0xA3 → 0x100 hits 0xA0, then 0x0 misses again.
4. Invalidate: after 2, pulse invalidate_i → next cycle addr 0x4 gives valid_o=0 and mem_req_o rises the following cycle.
5. Invalidate mid-refill: pulse on the 2nd beat → all 4 beats accepted, mem_req_o falls, FSM in IDLE, addr 0x0 misses and re-requests 0x0.
6. Async reset between beats 2 and 3 → mem_req_o and valid_o go to 0 without a clock edge; line 0 is invalid afterwards.
